// File: rtl/keypad_matrix_emulator.sv
// Emulates one held key on a 4x4 active-low keypad matrix for scripted gameplay input.
// A command presses one key for a set number of cycles, then forces a release gap.
module keypad_matrix_emulator #(
    parameter int unsigned HOLD_W      = 16,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned COL_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_action_i,
    input  logic [HOLD_W-1:0] cmd_hold_i,
    input  logic              flush_i,
    input  logic [3:0]        row_i,
    output logic [3:0]        col_o,
    output logic              key_active_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned GapW = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPress = 2'd1,
        StGap   = 2'd2
    } state_e;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : gen_gap_check
        $error("GAP_CYCLES must be in 1..255");
    end
    if (COL_LATENCY != 1) begin : gen_latency_check
        $error("COL_LATENCY other than 1 is unsupported");
    end
    if (HOLD_W < 1) begin : gen_hold_check
        $error("HOLD_W must be at least 1");
    end

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [1:0]        key_row_q, key_row_d;
    logic [1:0]        key_col_q, key_col_d;
    logic              key_en_q, key_en_d;
    logic [3:0]        col_q, col_d;

    logic              dec_en;
    logic [1:0]        dec_row;
    logic [1:0]        dec_col;
    logic              accept;
    logic              hold_last;
    logic              gap_last;

    // Action to (row, col) key map; unused codes become timing-only presses.
    always_comb begin
        dec_en  = 1'b0;
        dec_row = 2'd0;
        dec_col = 2'd0;
        case (cmd_action_i)
            3'd1: begin
                dec_en  = 1'b1;
                dec_row = 2'd1;
                dec_col = 2'd0;
            end
            3'd2: begin
                dec_en  = 1'b1;
                dec_row = 2'd1;
                dec_col = 2'd2;
            end
            3'd3: begin
                dec_en  = 1'b1;
                dec_row = 2'd0;
                dec_col = 2'd1;
            end
            3'd4: begin
                dec_en  = 1'b1;
                dec_row = 2'd3;
                dec_col = 2'd1;
            end
            default: begin
                dec_en  = 1'b0;
                dec_row = 2'd0;
                dec_col = 2'd0;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign accept      = cmd_valid_i && cmd_ready_o && !flush_i;
    // A zero count is treated as the final cycle so the counters never wrap.
    assign hold_last   = (hold_q <= HOLD_W'(1));
    assign gap_last    = (gap_q <= GapW'(1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
        key_en_d  = key_en_q;

        if (flush_i) begin
            state_d   = StIdle;
            hold_d    = '0;
            gap_d     = '0;
            key_row_d = 2'd0;
            key_col_d = 2'd0;
            key_en_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d   = StPress;
                        key_row_d = dec_row;
                        key_col_d = dec_col;
                        key_en_d  = dec_en;
                        hold_d    = (cmd_hold_i == '0) ? HOLD_W'(1) : cmd_hold_i;
                    end
                end
                StPress: begin
                    if (hold_last) begin
                        state_d = StGap;
                        hold_d  = '0;
                        gap_d   = GapW'(GAP_CYCLES);
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        state_d  = StIdle;
                        gap_d    = '0;
                        key_en_d = 1'b0;
                    end else begin
                        gap_d = gap_q - GapW'(1);
                    end
                end
                default: begin
                    state_d  = StIdle;
                    hold_d   = '0;
                    gap_d    = '0;
                    key_en_d = 1'b0;
                end
            endcase
        end
    end

    // Column answers the current row strobe one cycle later; only the latched key can pull low.
    always_comb begin
        col_d = 4'hF;
        if (!flush_i && state_q == StPress && key_en_q && !row_i[key_row_q]) begin
            col_d[key_col_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            gap_q     <= '0;
            key_row_q <= 2'd0;
            key_col_q <= 2'd0;
            key_en_q  <= 1'b0;
            col_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            key_en_q  <= key_en_d;
            col_q     <= col_d;
        end
    end

    assign col_o        = col_q;
    assign key_active_o = (state_q == StPress) && key_en_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StGap) && gap_last && !flush_i;

`ifndef SYNTHESIS
    a_one_col_low: assert property (@(posedge clk_i) disable iff (rst_i)
        $countones(~col_o) <= 1);
    a_done_in_gap: assert property (@(posedge clk_i) disable iff (rst_i)
        done_o |-> (state_q == StGap));
`endif

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: key map, timing, handshake, flush and reset.
module tb_keypad_matrix_emulator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_action_i;
    logic [15:0] cmd_hold_i;
    logic        flush_i;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        key_active_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_matrix_emulator #(
        .HOLD_W     (16),
        .GAP_CYCLES (8),
        .COL_LATENCY(1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_action_i(cmd_action_i),
        .cmd_hold_i  (cmd_hold_i),
        .flush_i     (flush_i),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_active_o(key_active_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer a command for one edge from IDLE; returns in the first PRESS cycle.
    task automatic issue(input logic [2:0] act, input logic [15:0] hold);
        cmd_valid_i  = 1'b1;
        cmd_action_i = act;
        cmd_hold_i   = hold;
        step();
        cmd_valid_i  = 1'b0;
    endtask

    // Bounded wait for done_o, then step into IDLE.
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 400) begin
            step();
            n++;
        end
        check_eq(tag, done_o, 1);
        step();
    endtask

    logic [3:0] rows [4];
    logic [3:0] exp_col;
    logic       any_ready, any_low, any_active;
    int         n, dn;

    initial begin
        rows[0] = 4'hE; rows[1] = 4'hD; rows[2] = 4'hB; rows[3] = 4'h7;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_action_i = 3'd0; cmd_hold_i = '0;
        flush_i = 1'b0; row_i = 4'hF;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_col", col_o, 4'hF);
        check_eq("rst_ready", cmd_ready_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_active", key_active_o, 0);
        check_eq("rst_done", done_o, 0);
        rst_i = 1'b0;

        // LEFT hold=5 with rows scanned E,D,B,7: col E follows each row D by one cycle.
        row_i = 4'hE;
        issue(3'd1, 16'd5);
        for (int p = 0; p < 5; p++) begin
            exp_col = (p > 0 && rows[(p - 1) % 4] == 4'hD) ? 4'hE : 4'hF;
            check_eq($sformatf("left_col_p%0d", p), col_o, exp_col);
            check_eq($sformatf("left_active_p%0d", p), key_active_o, 1);
            check_eq($sformatf("left_ready_p%0d", p), cmd_ready_o, 0);
            row_i = rows[p % 4];
            step();
        end
        row_i = 4'hD;
        for (int g = 1; g <= 8; g++) begin
            check_eq($sformatf("gap_col_g%0d", g), col_o, 4'hF);
            check_eq($sformatf("gap_active_g%0d", g), key_active_o, 0);
            check_eq($sformatf("gap_busy_g%0d", g), busy_o, 1);
            check_eq($sformatf("gap_done_g%0d", g), done_o, (g == 8) ? 1 : 0);
            step();
        end
        check_eq("left_ready_after", cmd_ready_o, 1);
        check_eq("left_busy_after", busy_o, 0);
        check_eq("left_done_after", done_o, 0);

        // ATTACK hold=0 acts as one PRESS cycle.
        row_i = 4'hE;
        issue(3'd3, 16'd0);
        check_eq("atk_active_p1", key_active_o, 1);
        check_eq("atk_col_p1", col_o, 4'hF);
        step();
        check_eq("atk_active_g1", key_active_o, 0);
        check_eq("atk_col_g1", col_o, 4'hD);
        step();
        check_eq("atk_col_g2", col_o, 4'hF);
        wait_done("atk_done");

        // SELECT hold=3 with every row driven low.
        row_i = 4'h0;
        issue(3'd4, 16'd3);
        check_eq("sel_col_p1", col_o, 4'hF);
        step();
        check_eq("sel_col_p2", col_o, 4'hD);
        step();
        check_eq("sel_col_p3", col_o, 4'hD);
        step();
        check_eq("sel_col_g1", col_o, 4'hD);
        step();
        check_eq("sel_col_g2", col_o, 4'hF);
        wait_done("sel_done");

        // NONE hold=3: timing-only, busy for 3+8 cycles with one done pulse.
        issue(3'd0, 16'd3);
        n = 0; dn = 0; any_low = 1'b0; any_active = 1'b0;
        while (busy_o && n < 50) begin
            if (col_o != 4'hF) any_low = 1'b1;
            if (key_active_o) any_active = 1'b1;
            if (done_o) dn++;
            n++;
            step();
        end
        check_eq("none_busy_cycles", n, 11);
        check_eq("none_col_low", any_low, 0);
        check_eq("none_active", any_active, 0);
        check_eq("none_done_count", dn, 1);

        // RIGHT held valid while busy is ignored, then taken on the first IDLE cycle.
        row_i = 4'hD;
        issue(3'd1, 16'd2);
        cmd_valid_i  = 1'b1;
        cmd_action_i = 3'd2;
        cmd_hold_i   = 16'd2;
        check_eq("bb_ready_press", cmd_ready_o, 0);
        step();
        check_eq("bb_left_col", col_o, 4'hE);
        n = 0; any_ready = 1'b0;
        while (!done_o && n < 40) begin
            if (cmd_ready_o) any_ready = 1'b1;
            n++;
            step();
        end
        check_eq("bb_done_seen", done_o, 1);
        check_eq("bb_ready_busy", any_ready, 0);
        step();
        check_eq("bb_ready_idle", cmd_ready_o, 1);
        check_eq("bb_busy_idle", busy_o, 0);
        step();
        cmd_valid_i = 1'b0;
        check_eq("bb_right_busy", busy_o, 1);
        check_eq("bb_right_active", key_active_o, 1);
        step();
        check_eq("bb_right_col", col_o, 4'hB);
        wait_done("bb_right_done");

        // RIGHT hold=100 flushed in PRESS cycle 10.
        issue(3'd2, 16'd100);
        repeat (9) step();
        check_eq("fl_col_before", col_o, 4'hB);
        flush_i = 1'b1;
        check_eq("fl_done_during", done_o, 0);
        step();
        flush_i = 1'b0;
        check_eq("fl_busy", busy_o, 0);
        check_eq("fl_ready", cmd_ready_o, 1);
        check_eq("fl_col", col_o, 4'hF);
        check_eq("fl_active", key_active_o, 0);
        check_eq("fl_done", done_o, 0);
        flush_i = 1'b1;
        issue(3'd1, 16'd5);
        flush_i = 1'b0;
        check_eq("fl_idle_no_accept", busy_o, 0);

        // Asynchronous reset between edges during a long RIGHT press.
        issue(3'd2, 16'd100);
        repeat (3) step();
        check_eq("ar_col_before", col_o, 4'hB);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("ar_col", col_o, 4'hF);
        check_eq("ar_ready", cmd_ready_o, 1);
        check_eq("ar_busy", busy_o, 0);
        check_eq("ar_active", key_active_o, 0);
        check_eq("ar_done", done_o, 0);
        step();
        rst_i = 1'b0;
        issue(3'd1, 16'd2);
        check_eq("ar_left_active", key_active_o, 1);
        step();
        check_eq("ar_left_col", col_o, 4'hE);
        wait_done("ar_left_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable responder for the 4×4 keypad matrix protocol. The keypad scanner drives active-low rows and samples active-low columns; this block answers those row strobes.
- It emulates a single key press, held for a commanded duration, so that a CPU/AI opponent (single-player mode) or a self-test sequencer can inject gameplay actions.
- Commands arrive through a valid/ready handshake. The block's column outputs feed the scanner's column inputs in place of a physical keypad.

Parameters:
- HOLD_W, 16, width of the hold-duration field in cycles.
- GAP_CYCLES, 8, forced all-released cycles after each press (1..255).
- COL_LATENCY, 1, registered row-to-column response delay in cycles (fixed at 1; any other value is unsupported).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  block can accept a command
- cmd_action_i  input  3  0=NONE, 1=LEFT, 2=RIGHT, 3=ATTACK, 4=SELECT, 5..7=NONE
- cmd_hold_i  input  HOLD_W  press duration in cycles; 0 is treated as 1
- flush_i  input  1  synchronous abort: release key, return to IDLE
- row_i  input  4  scanner row drive, active-low
- col_o  output  4  emulated column lines, active-low
- key_active_o  output  1  a key is currently held
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle pulse when the GAP phase completes

Behaviour:
- Reset (async, rst_i=1): state=IDLE, col_o=4'hF, cmd_ready_o=1, key_active_o=0, busy_o=0, done_o=0, hold and gap counters cleared, latched key cleared. Reset mid-press releases the key immediately (asynchronously).
- Key map (row,col), 0-based, one key per action:
  - LEFT = (1,0)
  - RIGHT = (1,2)
  - ATTACK = (0,1)
  - SELECT = (3,1)
  - NONE = no key (timing-only press)
- Handshake: a command is accepted on a rising edge where cmd_valid_i && cmd_ready_o. cmd_ready_o=1 only in IDLE (combinational from state). No queueing: commands offered while not ready are not captured.
- FSM:
  - IDLE: on accept, latch key (row, col, en) and the hold count (0 becomes 1); go to PRESS.
  - PRESS: key_active_o=1 if action != NONE. Hold counter decrements each cycle; after exactly max(hold,1) cycles in PRESS, go to GAP.
  - GAP: key released. Stays exactly GAP_CYCLES cycles; on the last cycle assert done_o for that cycle, then go to IDLE.
  - Back-to-back: a command valid in the first IDLE cycle after done_o is accepted that cycle.
- Column response, registered, 1-cycle latency: next col_o[c] = 0 iff key_en && state==PRESS && c==key_col && row_i[key_row]==0; otherwise 1.
  - Multiple rows low at once: respond if the key's row is among them.
  - row_i=4'hF (no row driven): col_o=4'hF.
  - Only one column is ever low at a time.
- Release timing: col_o returns to 4'hF on the first edge after PRESS ends, regardless of row_i.
- flush_i (priority below rst_i, above all else): next state=IDLE, counters cleared, col_o=4'hF next cycle, no done_o. flush_i asserted in IDLE while cmd_valid_i=1: no command is accepted that cycle.
- Counters saturate at zero and never wrap. Max hold = 2^HOLD_W-1 cycles.

Test Plan:
- Reset → col_o=F, cmd_ready_o=1. Accept LEFT hold=5 with row_i cycling E,D,B,7 (one row per cycle) → col_o=E exactly one cycle after each row_i=D sample, for 5 PRESS cycles. Then GAP 8 cycles with col_o=F. done_o pulses on cycle 8 of GAP. cmd_ready_o=1 the next cycle.
- ATTACK hold=0 with row_i=E held → exactly one PRESS cycle, so col_o=D for exactly one cycle (1-cycle delay), then F. key_active_o high for 1 cycle.
- SELECT hold=3 with row_i=0 (all rows low) → col_o=D for 3 cycles. NONE hold=3 with the same row_i → col_o stays F, busy_o=1 for 3+8 cycles, done_o pulses.
- cmd_valid_i held high with RIGHT during PRESS/GAP → not accepted (cmd_ready_o=0). It is accepted in the first IDLE cycle after done_o, and col_o=B appears when row_i=D.
- RIGHT hold=100, flush_i at PRESS cycle 10 → next cycle state=IDLE, col_o=F, no done_o, cmd_ready_o=1.
- RIGHT hold=100, rst_i pulsed mid-PRESS (asynchronously, between edges) → col_o=F immediately, all outputs at reset values; after release a new LEFT command is accepted normally.
